boot_loader_ctrl: RTL and testbench
===================================

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 The block SHALL take parameter MAX_WORDS, default 256, as the largest accepted image size in 32-bit words.
REQ-002 The block SHALL take parameter TIMEOUT_CYCLES, default 100000, as the maximum number of idle cycles allowed between bytes during a load.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have port load_req, input, 1 bit: one-cycle pulse that starts an image load.
REQ-006 The block SHALL have port rx_valid, input, 1 bit: a received byte is present this cycle (one-cycle pulse per byte).
REQ-007 The block SHALL have port rx_data, input, 8 bits: the received byte, valid when rx_valid=1.
REQ-008 The block SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-009 The block SHALL have port imem_addr, output, 32 bits: byte address of the word being written.
REQ-010 The block SHALL have port imem_wdata, output, 32 bits: the word being written.
REQ-011 The block SHALL have port cpu_reset, output, 1 bit: reset to the CPU datapath and its PC register.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a load is in progress.
REQ-013 The block SHALL have port load_done, output, 1 bit: one-cycle pulse when a load completes successfully.
REQ-014 The block SHALL have port load_err, output, 1 bit: level, high while in ERR.

Function
REQ-015 The controller SHALL be an FSM with states RUN, HDR0, HDR1, DATA, DONE and ERR.
REQ-016 In RUN, a load_req pulse SHALL move the FSM to HDR0 and clear the word index, byte index and timeout counter.
REQ-017 In HDR0, an accepted byte SHALL become count[7:0] and the FSM SHALL move to HDR1.
REQ-018 In HDR1, an accepted byte SHALL become count[15:8], making the header little-endian.
REQ-019 On leaving HDR1, the FSM SHALL go to ERR if count==0 or count>MAX_WORDS, and to DATA otherwise.
REQ-020 In DATA, bytes SHALL be packed little-endian: byte index 0 goes to bits [7:0] and byte index 3 goes to bits [31:24].
REQ-021 The byte index SHALL wrap 3→0.
REQ-022 In the cycle after the 4th byte of a word is accepted, imem_we SHALL be 1 for exactly one cycle, with imem_addr = word_idx*4 and imem_wdata = the packed word.
REQ-023 The word index SHALL then increment.
REQ-024 imem_addr and imem_wdata SHALL be registered and SHALL hold their last values when imem_we=0.
REQ-025 A byte arriving in the same cycle as an imem_we pulse SHALL be accepted into the next word without loss.
REQ-026 After the write of word count-1, the FSM SHALL enter DONE for one cycle, asserting load_done, and then return to RUN.
REQ-027 In HDR0, HDR1 and DATA, the timeout counter SHALL clear on every accepted byte and otherwise increment.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES-1 without a byte, the FSM SHALL enter ERR.
REQ-029 In ERR, load_req SHALL move the FSM to HDR0 with all indices cleared.
REQ-030 In ERR, rx_valid SHALL be ignored.
REQ-031 load_req SHALL be ignored in HDR0, HDR1, DATA and DONE.
REQ-032 rx_valid SHALL be ignored in RUN and DONE.
REQ-033 cpu_reset SHALL be 1 whenever reset=1 or the state is not RUN, so the CPU restarts at PC=0 on the first cycle of RUN after a load.
REQ-034 busy SHALL be 1 in HDR0, HDR1 and DATA.
REQ-035 Word index width SHALL be clog2(MAX_WORDS)+1.
REQ-036 imem_addr SHALL be {word_idx, 2'b00}, zero-extended to 32 bits.

Reset
REQ-037 While reset=1, the state SHALL be RUN.
REQ-038 While reset=1, cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, load_done=0 and load_err=0.
REQ-039 While reset=1, all counters and indices SHALL be 0.
REQ-040 Reset asserted mid-load SHALL abandon the load without any further imem_we pulse.
REQ-041 After reset is released, the CPU SHALL run the preloaded image.

Structure
REQ-042 The FSM state enum, the header byte count (2) and the bytes-per-word constant (4) SHALL reside in the shared package boot_pkg.
REQ-043 Byte packing SHALL be a sub-module rx_word_assembler with ports clk, reset, clr, byte_valid, byte_in and word_valid/word_out.

Verification
REQ-044 load_req; bytes 01 00 13 05 A0 00 → one imem_we with addr 0x0 and wdata 0x00A00513, then load_done one cycle later, then cpu_reset falls.
REQ-045 Header 03 00 followed by 12 bytes sent back-to-back → imem_we at addresses 0x0, 0x4 and 0x8 with correct little-endian words.
REQ-046 Header 00 00 → ERR, load_err=1, no imem_we; a subsequent load_req followed by a valid image → success.
REQ-047 Header 01 01 with MAX_WORDS=256 → ERR.
REQ-048 Header 02 00 then 5 bytes, then silence of TIMEOUT_CYCLES → ERR with exactly one imem_we.
REQ-049 Reset pulsed after 2 data bytes → state RUN, no imem_we, and a fresh load_req then loads correctly.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader: FSM states and
// header / word framing sizes.
package boot_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } boot_state_e;

endpackage

// File: rtl/rx_word_assembler.sv
// Packs a byte stream little-endian into 32-bit words. word_valid/word_out are
// presented combinationally with the last byte so the caller can register the write.
module rx_word_assembler
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_out
);

    localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
    localparam int unsigned PART_W = (BYTES_PER_WORD - 1) * BYTE_W;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PART_W-1:0] part_q, part_d;
    logic              last_byte_c;

    assign last_byte_c = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    always_comb begin
        idx_d  = idx_q;
        part_d = part_q;
        if (clr) begin
            idx_d  = '0;
            part_d = '0;
        end else if (byte_valid) begin
            idx_d = last_byte_c ? '0 : idx_q + IDX_W'(1);
            for (int i = 0; i < int'(BYTES_PER_WORD) - 1; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    part_d[i*BYTE_W +: BYTE_W] = byte_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            part_q <= '0;
        end else begin
            idx_q  <= idx_d;
            part_q <= part_d;
        end
    end

    assign word_valid = byte_valid && !clr && last_byte_c;
    assign word_out   = {byte_in, part_q};

endmodule

// File: rtl/boot_loader_ctrl.sv
// Serial boot loader: receives a 2-byte little-endian word count followed by the
// image bytes, writes words into instruction memory and holds the CPU in reset meanwhile.
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned MAX_WORDS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              imem_we,
    output logic [WORD_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned WIDX_W = $clog2(MAX_WORDS) + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned CNT_W  = HDR_BYTES * BYTE_W;

    boot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              start_c;
    logic              data_open_c;
    logic              tmo_exp_c;
    logic              count_bad_c;
    logic              last_written_c;
    logic [CNT_W-1:0]  hdr_count_c;
    logic              asm_valid;
    logic [WORD_W-1:0] asm_word;

    assign start_c        = load_req && (state_q == ST_RUN || state_q == ST_ERR);
    // Bytes beyond the announced image are dropped rather than packed.
    assign data_open_c    = (state_q == ST_DATA) && (CNT_W'(widx_q) < count_q);
    assign tmo_exp_c      = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign hdr_count_c    = {rx_data, count_q[BYTE_W-1:0]};
    assign count_bad_c    = (hdr_count_c == '0) || (32'(hdr_count_c) > MAX_WORDS);
    assign last_written_c = we_q && (CNT_W'(widx_q) == count_q);

    rx_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (start_c),
        .byte_valid (rx_valid && data_open_c),
        .byte_in    (rx_data),
        .word_valid (asm_valid),
        .word_out   (asm_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (load_req) state_d = ST_HDR0;
            ST_HDR0: begin
                if (rx_valid)       state_d = ST_HDR1;
                else if (tmo_exp_c) state_d = ST_ERR;
            end
            ST_HDR1: begin
                if (rx_valid)       state_d = count_bad_c ? ST_ERR : ST_DATA;
                else if (tmo_exp_c) state_d = ST_ERR;
            end
            ST_DATA: begin
                if (last_written_c)              state_d = ST_DONE;
                else if (!rx_valid && tmo_exp_c) state_d = ST_ERR;
            end
            ST_DONE: state_d = ST_RUN;
            ST_ERR:  if (load_req) state_d = ST_HDR0;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        busy_d = (state_d == ST_HDR0) || (state_d == ST_HDR1) || (state_d == ST_DATA);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
    end

    // Header capture, timeout tracking and the registered memory write port.
    always_comb begin
        count_d = count_q;
        widx_d  = widx_q;
        tmo_d   = tmo_q;
        we_d    = asm_valid;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start_c) begin
            count_d = '0;
            widx_d  = '0;
            tmo_d   = '0;
        end else if (state_q == ST_HDR0 || state_q == ST_HDR1 || state_q == ST_DATA) begin
            tmo_d = rx_valid ? '0 : tmo_q + TMO_W'(1);
            if (rx_valid && state_q == ST_HDR0) count_d[BYTE_W-1:0]     = rx_data;
            if (rx_valid && state_q == ST_HDR1) count_d[CNT_W-1:BYTE_W] = rx_data;
        end
        if (asm_valid) begin
            addr_d  = WORD_W'({widx_q, 2'b00});
            wdata_d = asm_word;
            widx_d  = widx_q + WIDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            widx_q  <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            widx_q  <= widx_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cpu_reset  = reset || (state_q != ST_RUN);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: directed loads push expected writes and
// completions; a negedge monitor pops and compares as the DUT produces them.
module tb_boot_loader_ctrl;

    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        load_done;
    logic        load_err;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   tests = 0;
    int   fails = 0;
    logic prev_we = 1'b0;

    boot_loader_ctrl #(.MAX_WORDS(256), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = a;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.addr    = '0;
        e.data    = '0;
        exp_q.push_back(e);
    endtask

    // Callers are always positioned just after a falling edge.
    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0 || exp_q[0].is_done) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h at %0t", imem_addr, imem_wdata, $time);
            end else begin
                e_mon = exp_q.pop_front();
                chk("wr_addr", imem_addr, e_mon.addr);
                chk("wr_data", imem_wdata, e_mon.data);
            end
        end
        if (load_done) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: load_done=1 with no completion pending at %0t", $time);
            end else begin
                e_mon = exp_q.pop_front();
                chk("done_one_cycle_after_write", 32'(prev_we), 32'd1);
            end
        end
        prev_we = imem_we;
    end

    initial begin
        reset    = 1'b1;
        load_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_we",        32'(imem_we), 32'd0);
        chk("rst_addr",      imem_addr, 32'd0);
        chk("rst_wdata",     imem_wdata, 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_done",      32'(load_done), 32'd0);
        chk("rst_err",       32'(load_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("run_cpu_reset", 32'(cpu_reset), 32'd0);

        // Single-word image
        push_wr(32'h0, 32'h00A00513);
        push_done();
        pulse_load();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_cpu_reset_hdr", 32'(cpu_reset), 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        rx_valid = 1'b0;
        chk("t1_we_cycle", 32'(imem_we), 32'd1);
        @(negedge clk);
        chk("t1_done_pulse", 32'(load_done), 32'd1);
        chk("t1_cpu_reset_done", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk("t1_cpu_reset_fall", 32'(cpu_reset), 32'd0);
        chk("t1_done_cleared", 32'(load_done), 32'd0);
        idle(3);

        // Three words back-to-back
        push_wr(32'h0, 32'h03020100);
        push_wr(32'h4, 32'h07060504);
        push_wr(32'h8, 32'h0B0A0908);
        push_done();
        pulse_load();
        send_byte(8'h03); send_byte(8'h00);
        for (int i = 0; i < 12; i++) send_byte(8'(i));
        idle(6);
        chk("t2_addr_hold",  imem_addr, 32'h8);
        chk("t2_wdata_hold", imem_wdata, 32'h0B0A0908);
        chk("t2_back_to_run", 32'(cpu_reset), 32'd0);

        // Zero-length header, ignored bytes in ERR, then recovery
        pulse_load();
        send_byte(8'h00); send_byte(8'h00);
        rx_valid = 1'b0;
        chk("t3_err", 32'(load_err), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        idle(2);
        chk("t3_err_hold", 32'(load_err), 32'd1);
        push_wr(32'h0, 32'hDEADBEEF);
        push_done();
        pulse_load();
        chk("t3_err_cleared", 32'(load_err), 32'd0);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        idle(4);
        chk("t3_recovered_run", 32'(cpu_reset), 32'd0);

        // Count 257 exceeds MAX_WORDS
        pulse_load();
        send_byte(8'h01); send_byte(8'h01);
        rx_valid = 1'b0;
        chk("t4_too_big_err", 32'(load_err), 32'd1);
        idle(2);

        // Timeout part-way through the second word
        push_wr(32'h0, 32'h44332211);
        pulse_load();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        idle(TMO - 1);
        chk("t5_not_yet_err", 32'(load_err), 32'd0);
        chk("t5_still_busy", 32'(busy), 32'd1);
        idle(1);
        chk("t5_timeout_err", 32'(load_err), 32'd1);
        idle(2);

        // Reset mid-load abandons it
        pulse_load();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_err", 32'(load_err), 32'd0);
        chk("t6_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t6_rst_addr", imem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_run_after_rst", 32'(cpu_reset), 32'd0);
        push_wr(32'h0, 32'h12345678);
        push_done();
        pulse_load();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        idle(5);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
